can_frame_rx: RTL and testbench
===============================

Name: can_frame_rx

Overview:
- Receive side of the CAN bus path; the complement of the bus checker, which watches what the transmitter puts on the wire.
- Samples one bus bit per clock and removes stuff bits.
- Parses standard (11-bit ID) data and remote frames, checks the CRC, and requests the ACK slot.
- Delivers ID, DLC and payload with a one-cycle valid pulse, and flags stuff, CRC and form errors.

Parameters:
- IDLE_BITS, 11, consecutive recessive bits required before an SOF is accepted (after reset, after any frame, after any error).
- MAX_BYTES, 8, payload buffer depth in bytes; DLC values above 8 are clamped to 8.

Ports:
- clock  in  1  bit clock; one bus bit per rising edge.
- reset  in  1  asynchronous, active-low reset; all state clears while reset is low.
- bus_data  in  1  sampled bus level; 1 = recessive, 0 = dominant.
- ack  out  1  ACK request; high for the one cycle in which the CRC delimiter is on the bus; the bus driver drives dominant in the next bit.
- frame_valid  out  1  one-cycle pulse on successful frame completion.
- rx_id  out  11  received identifier.
- rx_rtr  out  1  remote-frame flag.
- rx_dlc  out  4  received DLC (raw value).
- rx_data  out  64  payload; byte 0 in [63:56]; unused bytes are 0.
- stuff_err  out  1  one-cycle pulse.
- crc_err  out  1  one-cycle pulse.
- form_err  out  1  one-cycle pulse.
- busy  out  1  high from SOF until the end of EOF or an error.

Behaviour:
- Reset values: all outputs 0. State = WAIT_IDLE. Recessive counter, stuff run counter and CRC register = 0. Reset mid-frame discards the frame with no pulses.
- States:
  - WAIT_IDLE: count recessive bits; a dominant bit zeroes the count; at IDLE_BITS go to IDLE.
  - IDLE: a dominant bit is SOF → ARB, busy = 1. SOF counts as run bit 1 and as the first CRC input.
  - ARB: 11 ID bits, MSB first, then RTR (12 bits).
  - CTRL: IDE, r0, 4 DLC bits. IDE = 1 → form_err (extended frames not supported).
  - DATA: 8 × min(DLC, 8) bits; skipped when RTR = 1 or DLC = 0.
  - CRC: 15 bits.
  - CRC_DEL: one bit.
  - ACK_SLOT: one bit.
  - ACK_DEL: one bit.
  - EOF: 7 bits.
  - ERR: one cycle, then WAIT_IDLE.
- Destuffing, SOF through the last CRC bit:
  - Track the run length of identical bits.
  - After 5 identical bits, the next bit is a stuff bit: it is discarded from the field and CRC, and restarts the run at length 1 with its own value.
  - A stuff bit equal to the run value → stuff_err, go to ERR.
  - Stuffing is disabled from CRC_DEL onward; the stuff bit after the 15th CRC bit is still checked.
- CRC: CAN CRC-15, polynomial 0x4599, init 0. Shifts over destuffed bits SOF through the last data bit. The received 15 bits are compared against the register.
- ack timing:
  - Registered high at the edge sampling the last CRC bit (or its trailing stuff bit) when the CRC matches.
  - Low otherwise. High exactly one cycle, so it coincides with CRC_DEL on the bus.
  - CRC mismatch → no ack. crc_err pulses at the edge sampling ACK_DEL; go to ERR.
- Form checks, each → form_err and ERR:
  - CRC_DEL dominant.
  - ACK_DEL dominant.
  - Any EOF bit dominant.
  - ACK_SLOT is not checked; the receiver's own dominant bit is on the bus.
- Completion: at the edge sampling EOF bit 7, frame_valid pulses and busy drops.
  - rx_* update in the same cycle and hold until the next frame_valid.
  - Then WAIT_IDLE; the 7 EOF bits count toward IDLE_BITS, so 4 more recessive bits are needed.
- Errors: exactly one error pulse per frame; the first error wins. rx_* unchanged on error.
- Simultaneous events: a stuff violation on the bit after the 15th CRC bit takes priority; no ack is issued.

Decomposition:
- Package can_pkg holds:
  - state enum;
  - CAN_CRC_POLY = 15'h4599;
  - field lengths ID_W = 11, DLC_W = 4, CRC_W = 15, EOF_W = 7.
- One sub-module, can_destuff: bus_data in; bit_out, bit_valid (low on stuff bits), stuff_err out; enable from the FSM.
- The CRC-15 step lives as a function in can_pkg.

Test Plan:
- Data frame ID 0x123, RTR 0, DLC 2, data 0xAB 0xCD, correct CRC from the bench model, 11 recessive bits first → ack high exactly one cycle, aligned with CRC_DEL; frame_valid 1 cycle after EOF bit 7; rx_id = 0x123, rx_dlc = 2, rx_data = 0xABCD000000000000.
- Same frame with one data bit flipped (stuffing kept legal) → no ack, crc_err pulse at ACK_DEL, no frame_valid, rx_* unchanged.
- Six consecutive dominant bits inside the ID field → stuff_err on the 6th bit, then the block ignores a new SOF until 11 recessive bits have been seen.
- Remote frame ID 0x7FF, RTR 1, DLC 8 → no DATA field; frame_valid with rx_rtr = 1, rx_data = 0.
- DLC 0xF with 8 data bytes 0x00..0x07 → 64 data bits read; rx_dlc = 0xF; rx_data = 0x0001020304050607.
- Dominant bit at EOF bit 4 → form_err; reset driven low mid-DATA → all outputs 0 immediately and state WAIT_IDLE.

Source files
------------

// File: rtl/can_pkg.sv
// Shared types, field widths and the CRC-15 step for the CAN receive path.
package can_pkg;

    localparam int unsigned ID_W  = 11;
    localparam int unsigned DLC_W = 4;
    localparam int unsigned CRC_W = 15;
    localparam int unsigned EOF_W = 7;

    localparam logic [CRC_W-1:0] CAN_CRC_POLY = 15'h4599;

    typedef enum logic [3:0] {
        StWaitIdle,
        StIdle,
        StArb,
        StCtrl,
        StData,
        StCrc,
        StCrcDel,
        StAckSlot,
        StAckDel,
        StEof,
        StErr
    } state_e;

    function automatic logic [CRC_W-1:0] crc15_step(input logic [CRC_W-1:0] crc, input logic b);
        logic [CRC_W-1:0] sh;
        sh = {crc[CRC_W-2:0], 1'b0};
        return (b ^ crc[CRC_W-1]) ? (sh ^ CAN_CRC_POLY) : sh;
    endfunction

endpackage

// File: rtl/can_destuff.sv
// Bit destuffer: tracks runs of identical bus bits and flags stuff bits and stuff violations.
module can_destuff (
    input  logic clock,
    input  logic reset,
    input  logic bus_data,
    input  logic enable,
    output logic bit_out,
    output logic bit_valid,
    output logic stuff_err,
    output logic stuff_next
);

    logic [2:0] run_q;
    logic       last_q;
    logic       stuff;

    always_comb begin
        stuff      = enable && (run_q == 3'd5);
        bit_out    = bus_data;
        bit_valid  = !stuff;
        stuff_err  = stuff && (bus_data == last_q);
        // The bit now on the bus completes a run of five: the following bit must be a stuff bit.
        stuff_next = enable && !stuff && (bus_data == last_q) && (run_q == 3'd4);
    end

    // While disabled, each bit seeds a fresh run so the SOF starts the count at 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q  <= 3'd0;
            last_q <= 1'b0;
        end else begin
            if (!enable || stuff || (bus_data != last_q)) begin
                run_q <= 3'd1;
            end else begin
                run_q <= run_q + 3'd1;
            end
            last_q <= bus_data;
        end
    end

endmodule

// File: rtl/can_frame_rx.sv
// CAN standard-frame receiver: destuffs, parses, checks CRC and form, requests ACK.
module can_frame_rx
    import can_pkg::*;
#(
    parameter int unsigned IDLE_BITS = 11,
    parameter int unsigned MAX_BYTES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_data,
    output logic        ack,
    output logic        frame_valid,
    output logic [10:0] rx_id,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [63:0] rx_data,
    output logic        stuff_err,
    output logic        crc_err,
    output logic        form_err,
    output logic        busy
);

    localparam int unsigned IdleW = $clog2(IDLE_BITS + 1);

    state_e            state_q;
    logic [6:0]        bit_cnt_q;
    logic [IdleW-1:0]  idle_cnt_q;
    logic [ID_W-1:0]   id_q;
    logic              rtr_q;
    logic [DLC_W-1:0]  dlc_q;
    logic [63:0]       data_q;
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  crc_rx_q;
    logic              crc_ok_q;

    logic              ds_en, ds_bit, ds_valid, ds_err, ds_next;
    logic [DLC_W-1:0]  dlc_full;
    logic [DLC_W-1:0]  n_bytes;
    logic [6:0]        n_data_bits;
    logic [CRC_W-1:0]  crc_full;
    logic [5:0]        data_idx;

    always_comb begin
        ds_en       = state_q inside {StArb, StCtrl, StData, StCrc};
        dlc_full    = {dlc_q[DLC_W-2:0], ds_bit};
        n_bytes     = (32'(dlc_q) > MAX_BYTES) ? DLC_W'(MAX_BYTES) : dlc_q;
        n_data_bits = {n_bytes, 3'b000};
        crc_full    = {crc_rx_q[CRC_W-2:0], ds_bit};
        data_idx    = ~bit_cnt_q[5:0];
    end

    can_destuff u_destuff (
        .clock      (clock),
        .reset      (reset),
        .bus_data   (bus_data),
        .enable     (ds_en),
        .bit_out    (ds_bit),
        .bit_valid  (ds_valid),
        .stuff_err  (ds_err),
        .stuff_next (ds_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StWaitIdle;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            id_q        <= '0;
            rtr_q       <= 1'b0;
            dlc_q       <= '0;
            data_q      <= '0;
            crc_q       <= '0;
            crc_rx_q    <= '0;
            crc_ok_q    <= 1'b0;
            ack         <= 1'b0;
            frame_valid <= 1'b0;
            rx_id       <= '0;
            rx_rtr      <= 1'b0;
            rx_dlc      <= '0;
            rx_data     <= '0;
            stuff_err   <= 1'b0;
            crc_err     <= 1'b0;
            form_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ack         <= 1'b0;
            frame_valid <= 1'b0;
            stuff_err   <= 1'b0;
            crc_err     <= 1'b0;
            form_err    <= 1'b0;
            if (ds_err) begin
                stuff_err <= 1'b1;
                busy      <= 1'b0;
                state_q   <= StErr;
            end else begin
                case (state_q)
                    StWaitIdle: begin
                        if (!bus_data) begin
                            idle_cnt_q <= '0;
                        end else if (32'(idle_cnt_q) + 1 >= IDLE_BITS) begin
                            idle_cnt_q <= '0;
                            state_q    <= StIdle;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
                    StIdle: begin
                        if (!bus_data) begin
                            state_q   <= StArb;
                            busy      <= 1'b1;
                            bit_cnt_q <= '0;
                            crc_q     <= crc15_step('0, bus_data);
                            id_q      <= '0;
                            rtr_q     <= 1'b0;
                            dlc_q     <= '0;
                            data_q    <= '0;
                            crc_rx_q  <= '0;
                            crc_ok_q  <= 1'b0;
                        end
                    end
                    StArb: begin
                        if (ds_valid) begin
                            crc_q     <= crc15_step(crc_q, ds_bit);
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                            if (bit_cnt_q < 7'(ID_W)) begin
                                id_q <= {id_q[ID_W-2:0], ds_bit};
                            end else begin
                                rtr_q     <= ds_bit;
                                bit_cnt_q <= '0;
                                state_q   <= StCtrl;
                            end
                        end
                    end
                    StCtrl: begin
                        if (ds_valid) begin
                            crc_q     <= crc15_step(crc_q, ds_bit);
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                            if (bit_cnt_q == 7'd0 && ds_bit) begin
                                form_err <= 1'b1;
                                busy     <= 1'b0;
                                state_q  <= StErr;
                            end else if (bit_cnt_q >= 7'd2) begin
                                dlc_q <= dlc_full;
                                if (bit_cnt_q == 7'd5) begin
                                    bit_cnt_q <= '0;
                                    state_q   <= (rtr_q || dlc_full == '0) ? StCrc : StData;
                                end
                            end
                        end
                    end
                    StData: begin
                        if (ds_valid) begin
                            crc_q            <= crc15_step(crc_q, ds_bit);
                            data_q[data_idx] <= ds_bit;
                            bit_cnt_q        <= bit_cnt_q + 7'd1;
                            if (bit_cnt_q == n_data_bits - 7'd1) begin
                                bit_cnt_q <= '0;
                                state_q   <= StCrc;
                            end
                        end
                    end
                    StCrc: begin
                        // A count of CRC_W means only the trailing stuff bit is still owed.
                        if (!ds_valid) begin
                            if (bit_cnt_q == 7'(CRC_W)) begin
                                ack     <= crc_ok_q;
                                state_q <= StCrcDel;
                            end
                        end else begin
                            crc_rx_q  <= crc_full;
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                            if (bit_cnt_q == 7'(CRC_W - 1)) begin
                                crc_ok_q <= (crc_full == crc_q);
                                if (!ds_next) begin
                                    ack     <= (crc_full == crc_q);
                                    state_q <= StCrcDel;
                                end
                            end
                        end
                    end
                    StCrcDel: begin
                        if (!bus_data) begin
                            form_err <= 1'b1;
                            busy     <= 1'b0;
                            state_q  <= StErr;
                        end else begin
                            state_q <= StAckSlot;
                        end
                    end
                    StAckSlot: state_q <= StAckDel;
                    StAckDel: begin
                        if (!crc_ok_q) begin
                            crc_err <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StErr;
                        end else if (!bus_data) begin
                            form_err <= 1'b1;
                            busy     <= 1'b0;
                            state_q  <= StErr;
                        end else begin
                            bit_cnt_q <= '0;
                            state_q   <= StEof;
                        end
                    end
                    StEof: begin
                        if (!bus_data) begin
                            form_err <= 1'b1;
                            busy     <= 1'b0;
                            state_q  <= StErr;
                        end else if (bit_cnt_q == 7'(EOF_W - 1)) begin
                            frame_valid <= 1'b1;
                            busy        <= 1'b0;
                            rx_id       <= id_q;
                            rx_rtr      <= rtr_q;
                            rx_dlc      <= dlc_q;
                            rx_data     <= data_q;
                            // EOF bits already count toward the interframe idle requirement.
                            idle_cnt_q  <= IdleW'(EOF_W);
                            state_q     <= StWaitIdle;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                        end
                    end
                    StErr: begin
                        idle_cnt_q <= '0;
                        state_q    <= StWaitIdle;
                    end
                    default: state_q <= StWaitIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_can_frame_rx.sv
// Directed bench for can_frame_rx: builds stuffed frames with a CRC model and checks outputs.
module tb_can_frame_rx;

    logic        clock;
    logic        reset;
    logic        bus_data;
    logic        ack;
    logic        frame_valid;
    logic [10:0] rx_id;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        stuff_err;
    logic        crc_err;
    logic        form_err;
    logic        busy;

    can_frame_rx #(
        .IDLE_BITS (11),
        .MAX_BYTES (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus_data    (bus_data),
        .ack         (ack),
        .frame_valid (frame_valid),
        .rx_id       (rx_id),
        .rx_rtr      (rx_rtr),
        .rx_dlc      (rx_dlc),
        .rx_data     (rx_data),
        .stuff_err   (stuff_err),
        .crc_err     (crc_err),
        .form_err    (form_err),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    bit frame_q[$];
    int idx_crcdel, idx_ackdel, idx_eof;

    int ack_n, ack_at, fv_n, fv_at, se_n, se_at, ce_n, ce_at, fe_n, fe_at;
    bit busy_seen, busy_sof;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_evt();
        ack_n = 0; ack_at = -1; fv_n = 0; fv_at = -1; se_n = 0; se_at = -1;
        ce_n = 0; ce_at = -1; fe_n = 0; fe_at = -1; busy_seen = 0; busy_sof = 0;
    endtask

    // Drive on the falling edge, sample just after the rising edge that took the bit.
    task automatic send_bit(input bit b, input int i);
        @(negedge clock);
        bus_data = b;
        @(posedge clock);
        #1;
        if (ack)         begin ack_n++; ack_at = i; end
        if (frame_valid) begin fv_n++;  fv_at  = i; end
        if (stuff_err)   begin se_n++;  se_at  = i; end
        if (crc_err)     begin ce_n++;  ce_at  = i; end
        if (form_err)    begin fe_n++;  fe_at  = i; end
        if (busy) busy_seen = 1;
        if (i == 0) busy_sof = busy;
    endtask

    task automatic play(input int upto);
        for (int i = 0; i < upto; i++) send_bit(frame_q[i], i);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, -1);
    endtask

    // CRC by long division of msg * x^15 by the 16-bit generator 0xC599.
    task automatic build(input logic [10:0] id, input bit rtr, input logic [3:0] dlc,
                         input logic [63:0] data, input int flip);
        bit          raw[$];
        logic [15:0] r;
        logic [14:0] crc;
        int          nb, run;
        bit          last, m;
        raw = {};
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = (int'(dlc) > 8) ? 8 : int'(dlc);
        if (!rtr) for (int i = 0; i < nb * 8; i++) raw.push_back(data[63 - i]);
        r = '0;
        for (int i = 0; i < raw.size() + 15; i++) begin
            m = (i < raw.size()) ? raw[i] : 1'b0;
            r = {r[14:0], m};
            if (r[15]) r = r ^ 16'hC599;
        end
        crc = r[14:0];
        if (flip >= 0) raw[19 + flip] = !raw[19 + flip];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        frame_q = {};
        run = 0;
        last = 1'b0;
        foreach (raw[i]) begin
            frame_q.push_back(raw[i]);
            if (run > 0 && raw[i] == last) run++;
            else begin run = 1; last = raw[i]; end
            if (run == 5) begin
                frame_q.push_back(!last);
                last = !last;
                run = 1;
            end
        end
        idx_crcdel = frame_q.size();
        frame_q.push_back(1'b1);
        frame_q.push_back(1'b0);
        idx_ackdel = frame_q.size();
        frame_q.push_back(1'b1);
        idx_eof = frame_q.size();
        repeat (7) frame_q.push_back(1'b1);
    endtask

    initial begin
        reset = 1'b0;
        bus_data = 1'b1;
        clear_evt();
        repeat (3) @(posedge clock);
        #1;
        check("rst_outputs", 64'({ack, frame_valid, stuff_err, crc_err, form_err, busy}), 64'(0));
        check("rst_rx_id", 64'(rx_id), 64'(0));
        check("rst_rx_data", rx_data, 64'(0));
        check("rst_rx_ctl", 64'({rx_rtr, rx_dlc}), 64'(0));
        @(negedge clock);
        reset = 1'b1;

        // Data frame 0x123, DLC 2, 0xAB 0xCD
        idle_bits(11);
        build(11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1);
        clear_evt();
        play(frame_q.size());
        check("f1_busy_sof", 64'(busy_sof), 64'(1));
        check("f1_ack_n", 64'(ack_n), 64'(1));
        check("f1_ack_at", 64'(ack_at), 64'(idx_crcdel - 1));
        check("f1_fv_n", 64'(fv_n), 64'(1));
        check("f1_fv_at", 64'(fv_at), 64'(idx_eof + 6));
        check("f1_errs", 64'(se_n + ce_n + fe_n), 64'(0));
        check("f1_rx_id", 64'(rx_id), 64'h123);
        check("f1_rx_rtr", 64'(rx_rtr), 64'(0));
        check("f1_rx_dlc", 64'(rx_dlc), 64'(2));
        check("f1_rx_data", rx_data, 64'hABCD_0000_0000_0000);
        check("f1_busy_end", 64'(busy), 64'(0));

        // Same frame, last data bit flipped; only 4 idle bits after the previous EOF
        idle_bits(4);
        build(11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 15);
        clear_evt();
        play(frame_q.size());
        check("f2_ack_n", 64'(ack_n), 64'(0));
        check("f2_crc_err_n", 64'(ce_n), 64'(1));
        check("f2_crc_err_at", 64'(ce_at), 64'(idx_ackdel));
        check("f2_fv_n", 64'(fv_n), 64'(0));
        check("f2_other_errs", 64'(se_n + fe_n), 64'(0));
        check("f2_rx_data_held", rx_data, 64'hABCD_0000_0000_0000);
        check("f2_rx_id_held", 64'(rx_id), 64'h123);

        // Six dominant bits: SOF plus five ID bits
        idle_bits(12);
        frame_q = {};
        repeat (6) frame_q.push_back(1'b0);
        clear_evt();
        play(6);
        check("f3_stuff_err_n", 64'(se_n), 64'(1));
        check("f3_stuff_err_at", 64'(se_at), 64'(5));
        check("f3_busy", 64'(busy), 64'(0));
        // One bit in ERR, then only 10 recessive: a dominant bit must not start a frame
        clear_evt();
        idle_bits(11);
        send_bit(1'b0, -1);
        check("f3_sof_ignored", 64'(busy_seen), 64'(0));
        check("f3_no_pulses", 64'(se_n + ce_n + fe_n + fv_n + ack_n), 64'(0));

        // Remote frame 0x7FF, DLC 8
        idle_bits(11);
        build(11'h7FF, 1'b1, 4'd8, 64'h0, -1);
        clear_evt();
        play(frame_q.size());
        check("f4_fv_n", 64'(fv_n), 64'(1));
        check("f4_fv_at", 64'(fv_at), 64'(idx_eof + 6));
        check("f4_ack_at", 64'(ack_at), 64'(idx_crcdel - 1));
        check("f4_rx_id", 64'(rx_id), 64'h7FF);
        check("f4_rx_rtr", 64'(rx_rtr), 64'(1));
        check("f4_rx_dlc", 64'(rx_dlc), 64'(8));
        check("f4_rx_data", rx_data, 64'h0);

        // DLC 0xF clamps to 8 data bytes
        idle_bits(4);
        build(11'h055, 1'b0, 4'hF, 64'h0001_0203_0405_0607, -1);
        clear_evt();
        play(frame_q.size());
        check("f5_fv_n", 64'(fv_n), 64'(1));
        check("f5_rx_id", 64'(rx_id), 64'h055);
        check("f5_rx_dlc", 64'(rx_dlc), 64'hF);
        check("f5_rx_data", rx_data, 64'h0001_0203_0405_0607);

        // Dominant EOF bit 4
        idle_bits(4);
        build(11'h123, 1'b0, 4'd2, 64'h1122_0000_0000_0000, -1);
        frame_q[idx_eof + 3] = 1'b0;
        clear_evt();
        play(frame_q.size());
        check("f6_form_err_n", 64'(fe_n), 64'(1));
        check("f6_form_err_at", 64'(fe_at), 64'(idx_eof + 3));
        check("f6_fv_n", 64'(fv_n), 64'(0));
        check("f6_rx_data_held", rx_data, 64'h0001_0203_0405_0607);

        // Reset in the middle of the data field
        idle_bits(11);
        build(11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, -1);
        clear_evt();
        play(25);
        check("f7_busy_before", 64'(busy), 64'(1));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("f7_rst_outputs", 64'({ack, frame_valid, stuff_err, crc_err, form_err, busy}),
              64'(0));
        check("f7_rst_rx", 64'({rx_id, rx_rtr, rx_dlc}), 64'(0));
        check("f7_rst_rx_data", rx_data, 64'(0));
        @(negedge clock);
        reset = 1'b1;
        clear_evt();
        for (int i = 0; i < 5; i++) send_bit(1'b1, -1);
        send_bit(1'b0, -1);
        check("f7_wait_idle", 64'(busy_seen), 64'(0));
        idle_bits(11);
        clear_evt();
        play(frame_q.size());
        check("f7_fv_n", 64'(fv_n), 64'(1));
        check("f7_rx_data", rx_data, 64'hABCD_0000_0000_0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
